nf_cdc_tx_buf: RTL and testbench

Local-domain transmit buffer that sits directly upstream of the clock-domain-crossing register pair. It accepts a burst of words from a peripheral or bus write port into a small FIFO. It then launches them one at a time into the crossing block's write port (`cdc_we`/`cdc_data`), using the crossing block's `cdc_wait` as the completion handshake. Each word is launched only after the previous transfer has fully completed.

---
 rtl/nf_cdc_tx_buf.sv | 105 ++++++++++
 tb/tb_nf_cdc_tx_buf.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/nf_cdc_tx_buf.sv
// nf_cdc_tx_buf: local-domain transmit FIFO feeding the CDC register pair.
// Words are pushed in bursts and launched one at a time into the crossing
// block. The crossing block's cdc_wait is used as a rise/fall completion
// handshake before the next word goes out.
module nf_cdc_tx_buf #(
  parameter  int width = 8,
  parameter  int depth = 4,
  localparam int AW    = $clog2(depth),
  localparam int LW    = $clog2(depth) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [width-1:0] wr_data,
  output logic             full,
  output logic             empty,
  output logic [LW-1:0]    level,
  output logic             overflow,
  input  logic             ovf_clr,
  output logic             busy,
  output logic             cdc_we,
  output logic [width-1:0] cdc_data,
  input  logic             cdc_wait
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LAUNCH  = 2'd1,
    WAIT_HI = 2'd2,
    WAIT_LO = 2'd3
  } state_t;

  state_t                       state_q, state_d;
  logic [depth-1:0][width-1:0]  mem_q, mem_d;
  logic [AW-1:0]                rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]                wr_ptr_q, wr_ptr_d;
  logic [LW-1:0]                level_q, level_d;
  logic                         ovf_q, ovf_d;
  logic                         push, pop;

  // Fullness is judged on the pre-edge level, so a pop in the same cycle
  // never makes room for a push.
  assign full     = (level_q == LW'(depth));
  assign empty    = (level_q == '0);
  assign level    = level_q;
  assign overflow = ovf_q;
  assign busy     = (state_q != IDLE);
  assign cdc_we   = (state_q == LAUNCH);
  assign cdc_data = mem_q[rd_ptr_q];

  assign push = wr_en && !full;
  // LAUNCH is only entered with level != 0, so the pop is always valid.
  assign pop  = (state_q == LAUNCH);

  // Transfer FSM next-state: launch, then wait for cdc_wait to rise and fall.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (!empty && !cdc_wait) state_d = LAUNCH;
      LAUNCH:  state_d = WAIT_HI;
      WAIT_HI: if (cdc_wait)  state_d = WAIT_LO;
      WAIT_LO: if (!cdc_wait) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FIFO storage, pointers, level and sticky overflow next-state.
  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    level_d  = level_q;
    ovf_d    = ovf_q;
    if (push) begin
      mem_d[wr_ptr_q] = wr_data;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
    if (push && !pop)      level_d = level_q + LW'(1);
    else if (!push && pop) level_d = level_q - LW'(1);
    // A dropped push beats a simultaneous clear.
    if (wr_en && full) ovf_d = 1'b1;
    else if (ovf_clr)  ovf_d = 1'b0;
  end

  // State register; reset clears storage so cdc_data reads zero afterwards.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      mem_q    <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      level_q  <= level_d;
      ovf_q    <= ovf_d;
    end
  end

endmodule

// File: tb/tb_nf_cdc_tx_buf.sv
// Bench for nf_cdc_tx_buf: directed scenarios plus a randomized run checked
// against a queue-based reference model of the buffer and its handshake.
module tb_nf_cdc_tx_buf;
  localparam int W  = 8;
  localparam int D  = 4;
  localparam int LW = $clog2(D) + 1;

  logic          clk = 1'b0;
  logic          reset, wr_en, ovf_clr, cdc_wait;
  logic [W-1:0]  wr_data;
  logic          full, empty, overflow, busy, cdc_we;
  logic [LW-1:0] level;
  logic [W-1:0]  cdc_data;

  int checks = 0;
  int errors = 0;

  nf_cdc_tx_buf #(.width(W), .depth(D)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data),
    .full(full), .empty(empty), .level(level), .overflow(overflow),
    .ovf_clr(ovf_clr), .busy(busy), .cdc_we(cdc_we), .cdc_data(cdc_data),
    .cdc_wait(cdc_wait)
  );

  always #5 clk = ~clk;

  // Reference model: word queue, sticky overflow, handshake progress flags.
  logic [W-1:0] m_q[$];
  bit           m_ovf, m_strobe, m_busy, m_hi;
  // Crossing-block responder and collected strobes.
  int           hi_left;
  bit           pend;
  logic [W-1:0] got_q[$];
  int           b2b_cnt;
  bit           prev_we;

  task automatic model_edge(input bit w, input logic [W-1:0] d, input bit cw,
                            input bit clr, input bit rst);
    bit was_full;
    if (rst) begin
      m_q.delete(); m_ovf = 0; m_strobe = 0; m_busy = 0; m_hi = 0;
      return;
    end
    was_full = (m_q.size() == D);
    if (m_strobe) begin
      m_strobe = 0; m_busy = 1; m_hi = 0;
      void'(m_q.pop_front());
    end else if (m_busy) begin
      if (!m_hi) m_hi = cw;
      else if (!cw) m_busy = 0;
    end else if (m_q.size() != 0 && !cw) begin
      m_strobe = 1; m_busy = 1;
    end
    if (w && was_full) m_ovf = 1;
    else if (clr) m_ovf = 0;
    if (w && !was_full) m_q.push_back(d);
  endtask

  // Drive one cycle of inputs, advance the model, sample 1 time unit after the edge.
  task automatic tick(input bit w, input logic [W-1:0] d, input bit cw,
                      input bit clr, input bit rst);
    wr_en = w; wr_data = d; cdc_wait = cw; ovf_clr = clr; reset = rst;
    @(posedge clk);
    model_edge(w, d, cw, clr, rst);
    #1;
  endtask

  task automatic do_reset();
    tick(0, 0, 0, 0, 1);
    hi_left = 0; pend = 0; got_q.delete(); b2b_cnt = 0; prev_we = 0;
  endtask

  // Crossing-block model: wait rises the cycle after a strobe, holds 1..3 cycles.
  task automatic drain(input int max, output bit ok);
    bit cw;
    ok = 0;
    for (int i = 0; i < max; i++) begin
      if (pend) begin cw = 0; pend = 0; end
      else if (hi_left > 0) begin cw = 1; hi_left--; end
      else cw = 0;
      tick(0, 0, cw, 0, 0);
      if (cdc_we) begin
        got_q.push_back(cdc_data);
        if (prev_we) b2b_cnt++;
        hi_left = $urandom_range(1, 3); pend = 1;
      end
      prev_we = cdc_we;
      if (!busy && empty && hi_left == 0 && !pend) begin ok = 1; break; end
    end
  endtask

  task automatic test_reset();
    tick(1, 8'h5A, 0, 0, 1);
    tick(0, 0, 0, 0, 1);
    checks++; if (busy !== 1'b0 || cdc_we !== 1'b0) begin errors++;
      $display("FAIL reset_fsm busy=%b we=%b want 0 0", busy, cdc_we); end
    checks++; if (level !== '0 || empty !== 1'b1 || full !== 1'b0) begin errors++;
      $display("FAIL reset_fifo level=%0d empty=%b full=%b want 0 1 0", level, empty, full); end
    checks++; if (overflow !== 1'b0 || cdc_data !== 8'h00) begin errors++;
      $display("FAIL reset_out ovf=%b data=%h want 0 00", overflow, cdc_data); end
    do_reset();
  endtask

  task automatic test_single_word();
    int strobes = 0;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      tick(i == 0, 8'hA5, (i >= 3 && i <= 5), 0, 0);
      // Outputs now reflect cycle i+1.
      if (cdc_we) strobes++;
      if (i == 0) begin checks++; if (level !== 1) begin errors++;
        $display("FAIL single_level1 level=%0d want 1", level); end end
      if (i == 1) begin checks++; if (cdc_we !== 1'b1 || cdc_data !== 8'hA5) begin errors++;
        $display("FAIL single_strobe we=%b data=%h want 1 a5", cdc_we, cdc_data); end end
      if (i >= 2) begin checks++; if (empty !== 1'b1 || level !== 0) begin errors++;
        $display("FAIL single_empty c%0d empty=%b level=%0d want 1 0", i + 1, empty, level); end end
      checks++; if (busy !== (i >= 1 && i <= 5)) begin errors++;
        $display("FAIL single_busy c%0d busy=%b want %b", i + 1, busy, (i >= 1 && i <= 5)); end
    end
    checks++; if (strobes !== 1) begin errors++;
      $display("FAIL single_strobe_count got=%0d want 1", strobes); end
  endtask

  task automatic test_burst();
    bit ok;
    do_reset();
    for (int i = 0; i < 4; i++) tick(1, W'(i + 1), 1, 0, 0);
    checks++; if (full !== 1'b1 || level !== 4 || busy !== 1'b0) begin errors++;
      $display("FAIL burst_full full=%b level=%0d busy=%b want 1 4 0", full, level, busy); end
    drain(100, ok);
    checks++; if (!ok) begin errors++; $display("FAIL burst_timeout got=%0d want 1", ok); end
    checks++; if (got_q.size() !== 4) begin errors++;
      $display("FAIL burst_count got=%0d want 4", got_q.size()); end
    for (int i = 0; i < got_q.size() && i < 4; i++) begin
      checks++; if (got_q[i] !== W'(i + 1)) begin errors++;
        $display("FAIL burst_order idx=%0d got=%h want %h", i, got_q[i], W'(i + 1)); end
    end
    checks++; if (b2b_cnt !== 0) begin errors++;
      $display("FAIL burst_b2b got=%0d want 0", b2b_cnt); end
  endtask

  task automatic test_overflow();
    bit ok;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      tick(1, 8'hB0 + W'(i), 1, 0, 0);
      if (i == 3) begin checks++; if (overflow !== 1'b0 || full !== 1'b1) begin errors++;
        $display("FAIL ovf_pre ovf=%b full=%b want 0 1", overflow, full); end end
    end
    checks++; if (overflow !== 1'b1 || level !== 4) begin errors++;
      $display("FAIL ovf_set ovf=%b level=%0d want 1 4", overflow, level); end
    tick(0, 0, 1, 1, 0);
    checks++; if (overflow !== 1'b0) begin errors++;
      $display("FAIL ovf_clr ovf=%b want 0", overflow); end
    tick(1, 8'hEE, 1, 1, 0);
    checks++; if (overflow !== 1'b1 || level !== 4) begin errors++;
      $display("FAIL ovf_set_wins ovf=%b level=%0d want 1 4", overflow, level); end
    tick(0, 0, 1, 1, 0);
    drain(100, ok);
    checks++; if (!ok || got_q.size() !== 4) begin errors++;
      $display("FAIL ovf_drain ok=%0d count=%0d want 1 4", ok, got_q.size()); end
    for (int i = 0; i < got_q.size() && i < 4; i++) begin
      checks++; if (got_q[i] !== 8'hB0 + W'(i)) begin errors++;
        $display("FAIL ovf_data idx=%0d got=%h want %h", i, got_q[i], 8'hB0 + W'(i)); end
    end
  endtask

  task automatic test_deferred_launch();
    bit ok;
    do_reset();
    tick(1, 8'h3C, 1, 0, 0);
    for (int i = 0; i < 4; i++) begin
      tick(0, 0, 1, 0, 0);
      checks++; if (busy !== 1'b0 || cdc_we !== 1'b0 || level !== 1) begin errors++;
        $display("FAIL defer_hold busy=%b we=%b level=%0d want 0 0 1", busy, cdc_we, level); end
    end
    tick(0, 0, 0, 0, 0);
    checks++; if (cdc_we !== 1'b1 || cdc_data !== 8'h3C) begin errors++;
      $display("FAIL defer_strobe we=%b data=%h want 1 3c", cdc_we, cdc_data); end
    hi_left = 2; pend = 1;
    drain(50, ok);
    checks++; if (!ok) begin errors++; $display("FAIL defer_timeout got=%0d want 1", ok); end
  endtask

  task automatic test_push_during_pop();
    bit ok;
    do_reset();
    tick(1, 8'h11, 1, 0, 0);
    tick(1, 8'h22, 1, 0, 0);
    tick(0, 0, 0, 0, 0);
    checks++; if (cdc_we !== 1'b1 || level !== 2 || cdc_data !== 8'h11) begin errors++;
      $display("FAIL pdp_launch we=%b level=%0d data=%h want 1 2 11", cdc_we, level, cdc_data); end
    tick(1, 8'h77, 0, 0, 0);
    checks++; if (level !== 2 || cdc_we !== 1'b0) begin errors++;
      $display("FAIL pdp_level level=%0d we=%b want 2 0", level, cdc_we); end
    hi_left = 2; pend = 0;
    drain(100, ok);
    checks++; if (!ok || got_q.size() !== 2) begin errors++;
      $display("FAIL pdp_drain ok=%0d count=%0d want 1 2", ok, got_q.size()); end
    else begin
      checks++; if (got_q[0] !== 8'h22 || got_q[1] !== 8'h77) begin errors++;
        $display("FAIL pdp_order got=%h,%h want 22,77", got_q[0], got_q[1]); end
    end
  endtask

  task automatic test_reset_mid_transfer();
    int strobes = 0;
    do_reset();
    for (int i = 0; i < 4; i++) tick(1, 8'hC0 + W'(i), 1, 0, 0);
    tick(0, 0, 0, 0, 0);
    checks++; if (cdc_we !== 1'b1) begin errors++;
      $display("FAIL rmt_launch we=%b want 1", cdc_we); end
    tick(0, 0, 0, 0, 0);
    tick(0, 0, 1, 0, 0);
    tick(0, 0, 1, 0, 0);
    checks++; if (busy !== 1'b1 || level !== 3) begin errors++;
      $display("FAIL rmt_pre busy=%b level=%0d want 1 3", busy, level); end
    tick(0, 0, 1, 0, 1);
    checks++; if (busy !== 1'b0 || level !== 0 || empty !== 1'b1) begin errors++;
      $display("FAIL rmt_post busy=%b level=%0d empty=%b want 0 0 1", busy, level, empty); end
    for (int i = 0; i < 10; i++) begin
      tick(0, 0, 0, 0, 0);
      if (cdc_we) strobes++;
    end
    checks++; if (strobes !== 0 || busy !== 1'b0) begin errors++;
      $display("FAIL rmt_quiet strobes=%0d busy=%b want 0 0", strobes, busy); end
  endtask

  task automatic test_random();
    bit cw, ok;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      if (pend) begin cw = 0; pend = 0; end
      else if (hi_left > 0) begin cw = 1; hi_left--; end
      else cw = (!m_busy && $urandom_range(0, 9) == 0);
      tick($urandom_range(0, 9) < 4, W'($urandom), cw, $urandom_range(0, 19) == 0, 0);
      if (m_strobe) begin hi_left = $urandom_range(1, 4); pend = 1; end
      checks++; if (level !== LW'(m_q.size()) || full !== (m_q.size() == D) || empty !== (m_q.size() == 0)) begin
        errors++; $display("FAIL rand_level c%0d level=%0d full=%b empty=%b want %0d", c, level, full, empty, m_q.size()); end
      checks++; if (cdc_we !== m_strobe || busy !== m_busy) begin
        errors++; $display("FAIL rand_fsm c%0d we=%b busy=%b want %b %b", c, cdc_we, busy, m_strobe, m_busy); end
      checks++; if (overflow !== m_ovf) begin
        errors++; $display("FAIL rand_ovf c%0d ovf=%b want %b", c, overflow, m_ovf); end
      if (m_strobe && m_q.size() != 0) begin
        checks++; if (cdc_data !== m_q[0]) begin
          errors++; $display("FAIL rand_data c%0d data=%h want %h", c, cdc_data, m_q[0]); end
      end
    end
    drain(200, ok);
    checks++; if (!ok || m_q.size() != 0) begin errors++;
      $display("FAIL rand_drain ok=%0d model_left=%0d want 1 0", ok, m_q.size()); end
  endtask

  initial begin
    reset = 1; wr_en = 0; wr_data = '0; ovf_clr = 0; cdc_wait = 0;
    hi_left = 0; pend = 0; b2b_cnt = 0; prev_we = 0;
    test_reset();
    test_single_word();
    test_burst();
    test_overflow();
    test_deferred_launch();
    test_push_during_pop();
    test_reset_mid_transfer();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
